// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read, write and busy-set channels.
// The master drives addresses, write data and busy_set; the slave returns read data and busy state.
interface regfile_mp_if #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 2
);
    localparam int IDXW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    logic [NUM_READ*IDXW-1:0]  rs_addr;
    logic [NUM_READ*XLEN-1:0]  rs_data;
    logic [NUM_READ-1:0]       rs_busy;
    logic [NUM_WRITE-1:0]      wr_en;
    logic [NUM_WRITE*IDXW-1:0] wr_addr;
    logic [NUM_WRITE*XLEN-1:0] wr_data;
    logic                      busy_set;
    logic [IDXW-1:0]           busy_addr;
    logic [REG_COUNT-1:0]      busy_vec;

    modport master (
        output rs_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr,
        input  rs_data, rs_busy, busy_vec
    );

    modport slave (
        input  rs_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr,
        output rs_data, rs_busy, busy_vec
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register pending-producer (busy) tracking.
// x0 is hardwired to zero; optional same-cycle write-through to the read ports.
module regfile_mp #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 2,
    parameter int BYPASS    = 0
) (
    input logic        clk,
    input logic        rst,
    regfile_mp_if.slave bus
);
    localparam int IDXW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam logic [IDXW:0] REG_LIM = (IDXW+1)'(REG_COUNT);

    logic [XLEN-1:0]      regs   [REG_COUNT];
    logic [XLEN-1:0]      wr_val [REG_COUNT];
    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] wr_hit;
    logic [REG_COUNT-1:0] set_vec;
    logic [IDXW-1:0]      wa;
    logic [IDXW-1:0]      ra;

    // Address 0 and anything past the last register are never stored or tracked.
    function automatic logic addr_ok(input logic [IDXW-1:0] a);
        return (a != '0) && ({1'b0, a} < REG_LIM);
    endfunction

    // Ports are scanned in ascending order so the highest-numbered writer wins.
    always_comb begin
        wr_hit = '0;
        wa     = '0;
        for (int i = 0; i < REG_COUNT; i++) wr_val[i] = '0;
        for (int w = 0; w < NUM_WRITE; w++) begin
            wa = bus.wr_addr[w*IDXW +: IDXW];
            if (bus.wr_en[w] && addr_ok(wa)) begin
                wr_hit[wa] = 1'b1;
                wr_val[wa] = bus.wr_data[w*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        set_vec = '0;
        if (bus.busy_set && addr_ok(bus.busy_addr))
            set_vec[bus.busy_addr] = 1'b1;
    end

    // A set in the same cycle as a clear wins: it names a newer producer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
            busy_q <= '0;
        end else begin
            for (int i = 1; i < REG_COUNT; i++)
                if (wr_hit[i]) regs[i] <= wr_val[i];
            busy_q <= set_vec | (busy_q & ~wr_hit);
        end
    end

    assign bus.busy_vec = busy_q;

    always_comb begin
        bus.rs_data = '0;
        bus.rs_busy = '0;
        ra          = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            ra = bus.rs_addr[k*IDXW +: IDXW];
            if (!rst && addr_ok(ra)) begin
                bus.rs_data[k*XLEN +: XLEN] = regs[ra];
                bus.rs_busy[k]              = busy_q[ra];
                if (BYPASS != 0 && wr_hit[ra]) begin
                    bus.rs_data[k*XLEN +: XLEN] = wr_val[ra];
                    if (!set_vec[ra]) bus.rs_busy[k] = 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Drives a BYPASS=0 and a BYPASS=1 register file with identical stimulus and
// checks both against an array-based reference model.
module tb_regfile_mp;
    localparam int XL = 32;
    localparam int RC = 32;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int IW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*IW-1:0]  rs_addr;
    logic [NW-1:0]     wr_en;
    logic [NW*IW-1:0]  wr_addr;
    logic [NW*XL-1:0]  wr_data;
    logic              busy_set;
    logic [IW-1:0]     busy_addr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [XL-1:0] mr [RC];
    bit            mb [RC];

    regfile_mp_if #(.XLEN(XL), .REG_COUNT(RC), .NUM_READ(NR), .NUM_WRITE(NW)) if0 ();
    regfile_mp_if #(.XLEN(XL), .REG_COUNT(RC), .NUM_READ(NR), .NUM_WRITE(NW)) if1 ();

    assign if0.rs_addr = rs_addr;  assign if1.rs_addr = rs_addr;
    assign if0.wr_en   = wr_en;    assign if1.wr_en   = wr_en;
    assign if0.wr_addr = wr_addr;  assign if1.wr_addr = wr_addr;
    assign if0.wr_data = wr_data;  assign if1.wr_data = wr_data;
    assign if0.busy_set  = busy_set;  assign if1.busy_set  = busy_set;
    assign if0.busy_addr = busy_addr; assign if1.busy_addr = busy_addr;

    regfile_mp #(.XLEN(XL), .REG_COUNT(RC), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(0))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    regfile_mp #(.XLEN(XL), .REG_COUNT(RC), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(1))
        dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < RC; i++) begin
            mr[i] = '0;
            mb[i] = 1'b0;
        end
    endtask

    // Architectural effect of one clock edge: later ports overwrite earlier ones,
    // writes retire the pending producer, and a new busy_set is applied last.
    task automatic model_update();
        logic [IW-1:0] a;
        if (!rst) begin
            for (int w = 0; w < NW; w++) begin
                a = wr_addr[w*IW +: IW];
                if (wr_en[w] && a != 0) begin
                    mr[a] = wr_data[w*XL +: XL];
                    mb[a] = 1'b0;
                end
            end
            if (busy_set && busy_addr != 0) mb[busy_addr] = 1'b1;
        end
    endtask

    task automatic expect_out(input bit byp, output logic [NR*XL-1:0] d,
                              output logic [NR-1:0] b, output logic [RC-1:0] bv);
        logic [IW-1:0] a;
        logic [XL-1:0] dv;
        logic          bb;
        bit            hit;
        for (int k = 0; k < NR; k++) begin
            a  = rs_addr[k*IW +: IW];
            dv = '0;
            bb = 1'b0;
            if (!rst && a != 0) begin
                dv = mr[a];
                bb = mb[a];
                if (byp) begin
                    hit = 1'b0;
                    for (int w = 0; w < NW; w++)
                        if (wr_en[w] && wr_addr[w*IW +: IW] == a) begin
                            hit = 1'b1;
                            dv  = wr_data[w*XL +: XL];
                        end
                    if (hit && !(busy_set && busy_addr == a)) bb = 1'b0;
                end
            end
            d[k*XL +: XL] = dv;
            b[k] = bb;
        end
        for (int i = 0; i < RC; i++) bv[i] = mb[i];
    endtask

    task automatic check_all();
        logic [NR*XL-1:0] d;
        logic [NR-1:0]    b;
        logic [RC-1:0]    bv;
        expect_out(1'b0, d, b, bv);
        chk("dut0_rs_data", if0.rs_data, d);
        chk("dut0_rs_busy", if0.rs_busy, b);
        chk("dut0_busy_vec", if0.busy_vec, bv);
        expect_out(1'b1, d, b, bv);
        chk("dut1_rs_data", if1.rs_data, d);
        chk("dut1_rs_busy", if1.rs_busy, b);
        chk("dut1_busy_vec", if1.busy_vec, bv);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic edge_step();
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0; busy_set = 1'b0; busy_addr = '0;
    endtask

    task automatic wr(input int p, input logic [IW-1:0] a, input logic [XL-1:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*IW +: IW] = a;
        wr_data[p*XL +: XL] = d;
    endtask

    task automatic rd(input logic [IW-1:0] a0, input logic [IW-1:0] a1);
        rs_addr = {a1, a0};
    endtask

    function automatic logic [IW-1:0] raddr();
        return ($urandom % 2 == 0) ? IW'($urandom_range(0, 7)) : IW'($urandom_range(0, 31));
    endfunction

    initial begin
        logic [IW-1:0] a;
        rst = 1'b1;
        idle();
        rd(5'd1, 5'd2);
        model_clear();
        #12;
        chk("reset_rs_data0", if0.rs_data, 64'h0);
        chk("reset_busy_vec1", if1.busy_vec, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < RC; i++) begin
            a = IW'(i);
            rd(a, ~a);
            settle(); edge_step();
        end

        wr(0, 5'd0, 32'hFFFF_FFFF);
        settle(); edge_step();
        idle();
        wr(0, 5'd1, 32'h1234_5678);
        wr(1, 5'd2, 32'hDEAD_BEEF);
        settle(); edge_step();
        idle();
        rd(5'd0, 5'd1);
        settle();
        chk("x0_zero", if0.rs_data[31:0], 64'h0);
        chk("x1_val", if0.rs_data[63:32], 64'h1234_5678);
        edge_step();
        rd(5'd2, 5'd0);
        settle();
        chk("x2_val", if1.rs_data[31:0], 64'hDEAD_BEEF);
        edge_step();

        wr(0, 5'd5, 32'hAAAA_0001);
        wr(1, 5'd5, 32'hBBBB_0002);
        settle(); edge_step();
        idle();
        rd(5'd5, 5'd5);
        settle();
        chk("x5_high_port_wins", if0.rs_data[31:0], 64'hBBBB_0002);
        edge_step();
        wr(0, 5'd5, 32'hCCCC_0003);
        settle();
        chk("x5_nobypass_old", if0.rs_data[31:0], 64'hBBBB_0002);
        chk("x5_bypass_new", if1.rs_data[63:32], 64'hCCCC_0003);
        edge_step();
        idle();
        settle();
        chk("x5_after_edge", if0.rs_data[31:0], 64'hCCCC_0003);
        edge_step();

        busy_set = 1'b1; busy_addr = 5'd7;
        rd(5'd7, 5'd0);
        settle(); edge_step();
        idle();
        wr(0, 5'd7, 32'h0000_0777);
        settle();
        chk("busy7_set", 64'(if0.busy_vec[7]), 64'h1);
        chk("busy7_bypass_rs_busy", 64'(if1.rs_busy[0]), 64'h0);
        edge_step();
        idle();
        settle();
        chk("busy7_cleared", 64'(if0.busy_vec[7]), 64'h0);
        edge_step();
        busy_set = 1'b1; busy_addr = 5'd7;
        wr(1, 5'd7, 32'h0000_0778);
        settle(); edge_step();
        idle();
        settle();
        chk("busy7_set_wins", 64'(if1.busy_vec[7]), 64'h1);
        edge_step();

        busy_set = 1'b1; busy_addr = 5'd9;
        wr(0, 5'd9, 32'h0000_0099);
        settle(); edge_step();
        idle();
        rd(5'd9, 5'd9);
        settle();
        chk("x9_before_rst", if0.rs_data[31:0], 64'h99);
        edge_step();
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        chk("async_rst_busy_vec", if0.busy_vec, 64'h0);
        chk("async_rst_x9", if1.rs_data, 64'h0);
        wr(0, 5'd3, 32'h0000_0033);
        busy_set = 1'b1; busy_addr = 5'd3;
        rd(5'd3, 5'd3);
        settle();
        chk("rst_bypass_zero", if1.rs_data, 64'h0);
        edge_step();
        rst = 1'b0;
        idle();
        settle();
        chk("rst_write_dropped", if1.rs_data, 64'h0);
        chk("rst_busy_dropped", if0.busy_vec, 64'h0);
        edge_step();
        wr(1, 5'd4, 32'h0000_0044);
        busy_set = 1'b1; busy_addr = 5'd4;
        settle(); edge_step();
        idle();
        rd(5'd4, 5'd0);
        settle();
        chk("post_rst_write", if0.rs_data[31:0], 64'h44);
        chk("post_rst_busy", 64'(if0.busy_vec[4]), 64'h1);
        edge_step();

        for (int i = 0; i < 500; i++) begin
            idle();
            for (int w = 0; w < NW; w++)
                if ($urandom % 2 == 0) wr(w, raddr(), $urandom);
            busy_set  = ($urandom % 3 == 0);
            busy_addr = raddr();
            rd(raddr(), raddr());
            settle(); edge_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide these parameters:
- XLEN, default 32, data width.
- REG_COUNT, default 32, number of architectural registers; IDXW = clog2(REG_COUNT).
- NUM_READ, default 2, number of read ports.
- NUM_WRITE, default 2, number of write ports.
- BYPASS, default 0; 1 enables same-cycle write-through to the read ports.
REQ-002 SHALL provide these ports:
- clk  input  1  single clock, all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rs_addr  input  NUM_READ*IDXW  packed read addresses; port k uses slice k.
- rs_data  output  NUM_READ*XLEN  packed read data.
- rs_busy  output  NUM_READ  the register on port k has a pending producer.
- wr_en  input  NUM_WRITE  per-port write enable.
- wr_addr  input  NUM_WRITE*IDXW  packed write addresses.
- wr_data  input  NUM_WRITE*XLEN  packed write data.
- busy_set  input  1  mark register busy_addr as pending.
- busy_addr  input  IDXW  register to mark pending.
- busy_vec  output  REG_COUNT  registered pending bits, bit i for register i.

Function
REQ-003 Register 0 SHALL always read as zero and SHALL never be written or marked busy; rs_busy for address 0 SHALL always be 0.
REQ-004 Writes SHALL be synchronous: on the clk rise, each port with wr_en=1 and wr_addr!=0 updates its register.
REQ-005 When several write ports target the same address in one cycle, the highest-numbered port SHALL win.
REQ-006 Reads SHALL be combinational from rs_addr, with zero-cycle latency.
REQ-007 With BYPASS=0, a read of a register being written in the same cycle SHALL return the old value; the new value appears after the edge.
REQ-008 With BYPASS=1, a read of a register being written in the same cycle SHALL return that cycle's winning write data per REQ-005; address 0 is never bypassed.
REQ-009 The busy bit for register i SHALL set on a clk rise when busy_set=1 and busy_addr=i (i!=0).
REQ-010 The busy bit for register i SHALL clear on a clk rise when any write port writes i.
REQ-011 If a set and a clear target the same register in the same cycle, set SHALL win, because it represents a newer producer.
REQ-012 With BYPASS=0, rs_busy[k] SHALL equal busy_vec[rs_addr[k]].
REQ-013 With BYPASS=1, rs_busy[k] SHALL be 0 when the register is written this cycle and not also set this cycle; otherwise it equals busy_vec[rs_addr[k]].
REQ-014 busy_vec SHALL reflect registered state only, with no combinational path from inputs.
REQ-015 Out-of-range addresses (>= REG_COUNT) SHALL read zero, report not busy, and be ignored for writes and busy_set.
REQ-016 The block SHALL support NUM_READ from 1 to 8 and NUM_WRITE from 1 to 4 without RTL edits.

Reset
REQ-017 While rst=1, every register and every busy bit SHALL clear immediately, independent of clk.
REQ-018 While rst=1, rs_data SHALL be all zeros, rs_busy SHALL be 0 and busy_vec SHALL be 0.
REQ-019 Writes and busy_set presented while rst=1 SHALL be dropped.
REQ-020 Reset asserted mid-operation SHALL discard all pending busy bits.
REQ-021 On the first clk rise after rst deasserts, writes and busy_set SHALL take effect normally.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then read every address on all ports -> all 0, rs_busy=0, busy_vec=0.
- Write 0xFFFFFFFF to x0 via port 0; write 0x12345678 to x1 via port 0 and 0xDEADBEEF to x2 via port 1 in one cycle -> x0=0, x1=0x12345678, x2=0xDEADBEEF.
- Same cycle: port 0 writes x5=0xAAAA0001 and port 1 writes x5=0xBBBB0002 -> after the edge, x5=0xBBBB0002.
- Read x5 while writing 0xCCCC0003 -> BYPASS=0 returns the old value before the edge; BYPASS=1 returns 0xCCCC0003 in the same cycle.
- busy_set x7, then one cycle later write x7 -> busy_vec[7]=1 for exactly one cycle, then 0. In a separate cycle, busy_set x7 together with a write to x7 -> busy_vec[7] stays 1.
- busy_set x9, then assert rst asynchronously between edges -> busy_vec and x9 go to 0 immediately. Then run a 500-iteration randomized multi-port run against a reference model -> zero mismatches.
